mux_ula_operand_pipe: RTL and testbench

- Parametrised, registered successor to the ALU operand-A source selector in the multicycle datapath.
- Selects one of N_SRC operand buses, or a constant for unused selector codes, and stages the result in a 2-entry skid buffer with valid/ready handshake.
- Sits between the register/PC read stage and the ULA input. Lets the control FSM stall the ALU without losing a selected operand.

---
 rtl/mux_ula_operand_pipe.sv | 171 +++++++++++++++++
 tb/tb_mux_ula_operand_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_ula_operand_pipe.sv
// Registered ALU operand-A selector with a 2-entry skid buffer and valid/ready handshake.
// Optional sticky out-of-range selector flag (sel_err) enabled by defining MUX_ULA_SEL_CHECK_EN.
module mux_ula_operand_pipe #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 3,
  parameter int SEL_W = 2,
  parameter logic [WIDTH-1:0] CONST_VAL = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       seletor,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush
`ifdef MUX_ULA_SEL_CHECK_EN
  ,
  output logic                   sel_err
`endif
);

  localparam int N_TAB = 2**SEL_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic [SEL_W-1:0] main_sel_r;
  logic [WIDTH-1:0] skid_data_r;
  logic [SEL_W-1:0] skid_sel_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             load_main_s;
  logic             load_skid_s;
  logic             skid_to_main_s;
  logic [WIDTH-1:0] sel_val_s;
  logic [WIDTH-1:0] src_tab_s [N_TAB];

  // Codes beyond the last real source map to CONST_VAL, so the table covers every selector value.
  for (genvar k = 0; k < N_TAB; k++) begin : g_tab
    if (k < N_SRC) begin : g_src
      assign src_tab_s[k] = src_data[k*WIDTH +: WIDTH];
    end else begin : g_const
      assign src_tab_s[k] = CONST_VAL;
    end
  end

  assign sel_val_s  = src_tab_s[seletor];
  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Occupancy next-state and buffer load decisions; flush overrides everything.
  always_comb begin
    state_nxt_s    = state_r;
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            load_main_s = 1'b1;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            load_main_s = 1'b1;
            state_nxt_s = ST_ONE;
          end else if (in_xfer_s) begin
            load_skid_s = 1'b1;
            state_nxt_s = ST_FULL;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            skid_to_main_s = 1'b1;
            state_nxt_s    = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy state with handshake flags registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Main (output) and skid entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data_r <= {WIDTH{1'b0}};
      main_sel_r  <= {SEL_W{1'b0}};
      skid_data_r <= {WIDTH{1'b0}};
      skid_sel_r  <= {SEL_W{1'b0}};
    end else begin
      if (load_main_s) begin
        main_data_r <= sel_val_s;
        main_sel_r  <= seletor;
      end else if (skid_to_main_s) begin
        main_data_r <= skid_data_r;
        main_sel_r  <= skid_sel_r;
      end else begin
        main_data_r <= main_data_r;
        main_sel_r  <= main_sel_r;
      end
      if (load_skid_s) begin
        skid_data_r <= sel_val_s;
        skid_sel_r  <= seletor;
      end else begin
        skid_data_r <= skid_data_r;
        skid_sel_r  <= skid_sel_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data_r;
  assign out_sel   = main_sel_r;

`ifdef MUX_ULA_SEL_CHECK_EN
  logic sel_err_r;
  logic sel_oor_s;

  assign sel_oor_s = (int'(seletor) >= N_SRC);

  // Sticky flag for accepted out-of-range selects; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_err_r | (in_xfer_s & ~flush & sel_oor_s);
    end
  end

  assign sel_err = sel_err_r;
`endif

endmodule

// File: tb/tb_mux_ula_operand_pipe.sv
// Scoreboard bench for mux_ula_operand_pipe: accepted entries are queued with their
// expected operand and compared in order as the ULA side consumes them.
module tb_mux_ula_operand_pipe;

  localparam int WIDTH = 32;
  localparam int N_SRC = 3;
  localparam int SEL_W = 2;
  localparam logic [31:0] CONST_VAL = 32'h0000FFFF;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [95:0] src_data = 96'h0;
  logic [1:0]  seletor = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
`ifdef MUX_ULA_SEL_CHECK_EN
  logic        sel_err;
`endif

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          out_count = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_data = 32'h0;
  logic [1:0]  hold_sel = 2'd0;

  mux_ula_operand_pipe #(
    .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .CONST_VAL(CONST_VAL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .seletor(seletor),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush)
`ifdef MUX_ULA_SEL_CHECK_EN
    , .sel_err(sel_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_val(input logic [95:0] src, input logic [1:0] sel);
    case (sel)
      2'd0: return src[31:0];
      2'd1: return src[63:32];
      2'd2: return src[95:64];
      default: return CONST_VAL;
    endcase
  endfunction

  // Scoreboard sampling at the falling edge, where inputs and outputs are settled.
  task automatic mon();
    if (!reset_n) begin
      hold_valid = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data=%h sel=%0d, required no output", out_data, out_sel);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data || out_sel !== mon_e.sel) begin
            errors++;
            $display("FAIL sb_output: got data=%h sel=%0d, required data=%h sel=%0d",
                     out_data, out_sel, mon_e.data, mon_e.sel);
          end
        end
      end
      if (out_valid && !out_ready) begin
        if (hold_valid) begin
          checks++;
          if (out_data !== hold_data || out_sel !== hold_sel) begin
            errors++;
            $display("FAIL stall_stable: got data=%h sel=%0d, required data=%h sel=%0d",
                     out_data, out_sel, hold_data, hold_sel);
          end
        end
        hold_valid = 1'b1;
        hold_data  = out_data;
        hold_sel   = out_sel;
      end else begin
        hold_valid = 1'b0;
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back('{data: model_val(src_data, seletor), sel: seletor});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h sel=%0d, required 1 0 0 0",
               in_ready, out_valid, out_data, out_sel);
    end
`ifdef MUX_ULA_SEL_CHECK_EN
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_sel_err: got %b, required 0", sel_err);
    end
`endif
    // Fill to FULL, then reset between edges.
    out_ready = 1'b0;
    src_data = {32'h0, 32'hA5A5_0001, 32'h0000_0010};
    in_valid = 1'b1; seletor = 2'd1;
    step();
    seletor = 2'd0;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready: got %b, required 0", in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_full: got rdy=%b vld=%b data=%h, required 1 0 0", in_ready, out_valid, out_data);
    end
    sb.delete();
    step();
    reset_n = 1'b1;
    // Single transfer with one-cycle latency.
    src_data = {32'h0, 32'hA5A5_0001, 32'h0040_0000};
    seletor = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0040_0000 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL single_latency: got vld=%b data=%h sel=%0d, required 1 00400000 0", out_valid, out_data, out_sel);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle: got vld=%b, required 0", out_valid);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    src_data = {32'h0, 32'hDEAD_BEEF, 32'h0000_0004};
    in_valid = 1'b1; seletor = 2'd1;
    step();
    seletor = 2'd0;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hDEAD_BEEF || out_sel !== 2'd1) begin
      errors++;
      $display("FAIL bp_fill: got rdy=%b data=%h sel=%0d, required 0 deadbeef 1", in_ready, out_data, out_sel);
    end
    repeat (2) step();
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0004 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: got vld=%b data=%h rdy=%b, required 1 00000004 1", out_valid, out_data, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain2: got vld=%b, required 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    int base;
    base = out_count;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_data = {32'h0, $urandom, $urandom};
      seletor = 2'(i % 3);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready: cycle %0d got %b, required 1", i, in_ready);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_out_valid: cycle %0d got %b, required 1", i, out_valid);
        end
      end
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_count - base !== 8 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_count: got %0d outputs vld=%b, required 8 outputs vld=0", out_count - base, out_valid);
    end
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    src_data = {32'h0, 32'h1111_2222, 32'h3333_4444};
    seletor = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'h0000_FFFF || out_sel !== 2'd3) begin
      errors++;
      $display("FAIL oor_const: got data=%h sel=%0d, required 0000ffff 3", out_data, out_sel);
    end
    seletor = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
`ifdef MUX_ULA_SEL_CHECK_EN
    checks++;
    if (sel_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky: got %b, required 1", sel_err);
    end
`endif
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    src_data = {32'h0, 32'hCAFE_0001, 32'hCAFE_0000};
    in_valid = 1'b1; seletor = 2'd0;
    step();
    seletor = 2'd1;
    step();
    flush = 1'b1; seletor = 2'd2;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    // Flush with an accepted-looking offer in EMPTY: the entry must vanish.
    seletor = 2'd1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got vld=%b, required 0", out_valid);
    end
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    src_data = {32'h0, 32'h1234_5678, 32'h0};
    in_valid = 1'b1; seletor = 2'd1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL async_pre: got vld=%b data=%h, required 1 12345678", out_valid, out_data);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got vld=%b data=%h sel=%0d rdy=%b, required 0 0 0 1",
               out_valid, out_data, out_sel, in_ready);
    end
    sb.delete();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_back_pressure();
    test_streaming();
    test_out_of_range();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
